dpram_arb: RTL and testbench

DPRAM_ARB -- requirements
Module: dpram_arb

---
 rtl/dpram_pkg.sv | 27 ++
 rtl/dpram.sv | 33 +++
 rtl/dpram_arb.sv | 165 ++++++++++++++++
 tb/tb_dpram_arb.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/dpram_pkg.sv
// Shared widths, read-FSM encoding and small helpers for the dual-port RAM arbiter.
package dpram_pkg;

   localparam int WA_W = 6;    // byte write address
   localparam int WD_W = 8;    // byte write data
   localparam int RA_W = 5;    // word read address
   localparam int RD_W = 16;   // word read data

   typedef enum logic {
      RD_IDLE = 1'b0,
      RD_WAIT = 1'b1
   } rd_state_e;

   // One captured byte write, as presented to the RAM write port.
   typedef struct packed {
      logic [WA_W-1:0] wa;
      logic [WD_W-1:0] wd;
   } wr_req_t;

   // A read address collides with a write when the write lands in either byte of that word.
   function automatic logic rd_hazard(input logic            we,
                                      input logic [WA_W-1:0] wa,
                                      input logic [RA_W-1:0] ra);
      return we && (wa[WA_W-1:1] == ra);
   endfunction

endpackage

// File: rtl/dpram.sv
// 64x8 write / 32x16 read dual-port RAM with a registered read port.
// Word w is {byte[2w+1], byte[2w]}. Contents are never reset.
module dpram
   import dpram_pkg::*;
(
   input  logic            clk,
   input  logic            we,
   input  logic [WA_W-1:0] wa,
   input  logic [WD_W-1:0] wd,
   input  logic [RA_W-1:0] ra,
   output logic [RD_W-1:0] rd
);

   logic [WD_W-1:0] mem_q [0:(1<<WA_W)-1];
   logic [RD_W-1:0] rd_d;
   logic [RD_W-1:0] rd_q;

   // Little-endian word assembly from the two bytes addressed by ra.
   always_comb begin
      rd_d = {mem_q[{ra, 1'b1}], mem_q[{ra, 1'b0}]};
   end

   // Byte write and registered word read; a read at the same edge as a write sees old data.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[wa] <= wd;
      end
      rd_q <= rd_d;
   end

   assign rd = rd_q;

endmodule

// File: rtl/dpram_arb.sv
// Two-client byte-write arbiter plus word-read FSM in front of a single dpram.
// Writes: the winner's wa/wd are registered and its gnt pulses together with RAM we.
// Reads: r_addr goes straight onto the RAM address in IDLE so data is back two cycles
// after acceptance; a write to the same word in the accept cycle forces one re-read.
module dpram_arb
   import dpram_pkg::*;
#(
   parameter int RR = 1
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            a_req,
   input  logic [WA_W-1:0] a_wa,
   input  logic [WD_W-1:0] a_wd,
   output logic            a_gnt,
   input  logic            b_req,
   input  logic [WA_W-1:0] b_wa,
   input  logic [WD_W-1:0] b_wd,
   output logic            b_gnt,
   input  logic            r_req,
   input  logic [RA_W-1:0] r_addr,
   output logic            r_busy,
   output logic            r_valid,
   output logic [RD_W-1:0] r_data
);

   // write side
   logic      a_win, b_win;
   logic      a_gnt_d, a_gnt_q;
   logic      b_gnt_d, b_gnt_q;
   logic      we_d, we_q;
   logic      last_b_d, last_b_q;   // 1: B was granted most recently
   wr_req_t   wr_d, wr_q;

   // read side
   rd_state_e       st_d, st_q;
   logic [RA_W-1:0] ra_d, ra_q;
   logic            hz_d, hz_q;     // re-read pending because of a same-word write
   logic            r_busy_d, r_busy_q;
   logic            r_valid_d, r_valid_q;
   logic [RD_W-1:0] r_data_d, r_data_q;
   logic [RA_W-1:0] ram_ra;
   logic [RD_W-1:0] ram_rd;

   // Pick at most one writer per edge; round-robin or A-first on contention.
   always_comb begin
      a_win = a_req;
      b_win = b_req;
      if (a_req && b_req) begin
         if (RR != 0) begin
            a_win = last_b_q;
            b_win = !last_b_q;
         end else begin
            a_win = 1'b1;
            b_win = 1'b0;
         end
      end
   end

   // Next-state for the write pipeline: capture winner, pulse its gnt with we.
   always_comb begin
      a_gnt_d  = a_win;
      b_gnt_d  = b_win;
      we_d     = a_win || b_win;
      wr_d     = b_win ? wr_req_t'{wa: b_wa, wd: b_wd} : wr_req_t'{wa: a_wa, wd: a_wd};
      last_b_d = last_b_q;
      if (b_win) begin
         last_b_d = 1'b1;
      end else if (a_win) begin
         last_b_d = 1'b0;
      end
   end

   // Write-side registers; reset drops any pending grant and makes A the last winner.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_gnt_q  <= 1'b0;
         b_gnt_q  <= 1'b0;
         we_q     <= 1'b0;
         last_b_q <= 1'b0;
         wr_q     <= '0;
      end else begin
         a_gnt_q  <= a_gnt_d;
         b_gnt_q  <= b_gnt_d;
         we_q     <= we_d;
         last_b_q <= last_b_d;
         wr_q     <= wr_d;
      end
   end

   // RAM address: live r_addr while idle so the RAM samples it at the accept edge.
   always_comb begin
      ram_ra = (st_q == RD_IDLE) ? r_addr : ra_q;
   end

   // Read FSM next-state: IDLE accepts, WAIT delivers (after one re-read on a hazard).
   always_comb begin
      st_d      = st_q;
      ra_d      = ra_q;
      hz_d      = hz_q;
      r_busy_d  = r_busy_q;
      r_valid_d = 1'b0;
      r_data_d  = r_data_q;
      case (st_q)
         RD_IDLE: begin
            if (r_req) begin
               ra_d     = r_addr;
               hz_d     = rd_hazard(we_q, wr_q.wa, r_addr);
               r_busy_d = 1'b1;
               st_d     = RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (hz_q) begin
               hz_d = 1'b0;
            end else begin
               r_data_d  = ram_rd;
               r_valid_d = 1'b1;
               r_busy_d  = 1'b0;
               st_d      = RD_IDLE;
            end
         end
         default: begin
            st_d     = RD_IDLE;
            hz_d     = 1'b0;
            r_busy_d = 1'b0;
         end
      endcase
   end

   // Read FSM state and registered outputs; reset abandons any read in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         st_q      <= RD_IDLE;
         ra_q      <= '0;
         hz_q      <= 1'b0;
         r_busy_q  <= 1'b0;
         r_valid_q <= 1'b0;
         r_data_q  <= '0;
      end else begin
         st_q      <= st_d;
         ra_q      <= ra_d;
         hz_q      <= hz_d;
         r_busy_q  <= r_busy_d;
         r_valid_q <= r_valid_d;
         r_data_q  <= r_data_d;
      end
   end

   dpram u_ram (
      .clk (clk),
      .we  (we_q),
      .wa  (wr_q.wa),
      .wd  (wr_q.wd),
      .ra  (ram_ra),
      .rd  (ram_rd)
   );

   assign a_gnt   = a_gnt_q;
   assign b_gnt   = b_gnt_q;
   assign r_busy  = r_busy_q;
   assign r_valid = r_valid_q;
   assign r_data  = r_data_q;

endmodule

// File: tb/tb_dpram_arb.sv
// Directed bench for dpram_arb: one round-robin and one fixed-priority instance
// share the same stimulus; inputs change and outputs are sampled on the falling edge.
module tb_dpram_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_req, b_req, r_req;
   logic [5:0]  a_wa, b_wa;
   logic [7:0]  a_wd, b_wd;
   logic [4:0]  r_addr;

   logic        a_gnt, b_gnt, r_busy, r_valid;
   logic [15:0] r_data;
   logic        fa_gnt, fb_gnt, f_busy, f_valid;
   logic [15:0] f_data;

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [15:0] d;
   int          na, nb, np, nbad, nv;

   always #5 clk = ~clk;

   dpram_arb #(.RR(1)) u_rr (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_wa(a_wa), .a_wd(a_wd), .a_gnt(a_gnt),
      .b_req(b_req), .b_wa(b_wa), .b_wd(b_wd), .b_gnt(b_gnt),
      .r_req(r_req), .r_addr(r_addr), .r_busy(r_busy), .r_valid(r_valid), .r_data(r_data)
   );

   dpram_arb #(.RR(0)) u_fp (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_wa(a_wa), .a_wd(a_wd), .a_gnt(fa_gnt),
      .b_req(b_req), .b_wa(b_wa), .b_wd(b_wd), .b_gnt(fb_gnt),
      .r_req(r_req), .r_addr(r_addr), .r_busy(f_busy), .r_valid(f_valid), .r_data(f_data)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(negedge clk);
   endtask

   // Issue one read on the round-robin instance, check its latency, return the data.
   task automatic rd(input logic [4:0] addr, input int lat_exp, output logic [15:0] dout);
      int n;
      r_req  = 1'b1;
      r_addr = addr;
      tick;
      r_req = 1'b0;
      n = 1;
      while (!r_valid && n < 8) begin
         tick;
         n++;
      end
      chk("rd_lat", 32'(n), 32'(lat_exp));
      dout = r_data;
   endtask

   initial begin
      rst = 1'b1;
      a_req = 1'b0; b_req = 1'b0; r_req = 1'b0;
      a_wa = '0; a_wd = '0; b_wa = '0; b_wd = '0; r_addr = '0;
      tick;
      tick;

      // reset state
      chk("rst_gnt",   32'({a_gnt, b_gnt, fa_gnt, fb_gnt}), 32'd0);
      chk("rst_busy",  32'({r_busy, f_busy}), 32'd0);
      chk("rst_valid", 32'({r_valid, f_valid}), 32'd0);
      chk("rst_data",  32'(r_data), 32'd0);
      chk("rst_fdata", 32'(f_data), 32'd0);
      rst = 1'b0;

      // A writes 05@0, 06@1, 07@2 back to back
      a_req = 1'b1; a_wa = 6'd0; a_wd = 8'h05;
      tick; chk("wr0_gnt", 32'({a_gnt, b_gnt}), 32'h2);
      a_wa = 6'd1; a_wd = 8'h06;
      tick; chk("wr1_gnt", 32'({a_gnt, b_gnt}), 32'h2);
      a_wa = 6'd2; a_wd = 8'h07;
      tick; chk("wr2_gnt", 32'({a_gnt, b_gnt}), 32'h2);
      a_req = 1'b0;
      tick; chk("wr_idle", 32'({a_gnt, b_gnt}), 32'h0);

      rd(5'd0, 2, d); chk("rd_w0", 32'(d), 32'h0605);
      rd(5'd1, 2, d); chk("rd_w1", 32'(d & 16'h00FF), 32'h0007);

      // hazard: write 0xAA@9 in the cycle that word 4 is presented
      a_req = 1'b1; a_wa = 6'd8; a_wd = 8'h33;
      tick;
      a_wa = 6'd9; a_wd = 8'hAA;
      tick;
      a_req = 1'b0;
      rd(5'd4, 3, d); chk("hz_data", 32'(d), 32'hAA33);

      // a write to a neighbouring word must not stretch the read
      a_req = 1'b1; a_wa = 6'd11; a_wd = 8'h5A;
      tick;
      a_req = 1'b0;
      rd(5'd4, 2, d); chk("nohz_data", 32'(d), 32'hAA33);
      rd(5'd5, 2, d); chk("nohz_w5", 32'(d[15:8]), 32'h5A);

      // reset at the edge a write would win: no grant, RAM untouched
      a_req = 1'b1; a_wa = 6'd0; a_wd = 8'hFF; rst = 1'b1;
      tick; chk("rstwr_gnt", 32'(a_gnt), 32'd0);
      a_req = 1'b0; rst = 1'b0;
      tick; chk("rstwr_gnt2", 32'(a_gnt), 32'd0);
      rd(5'd0, 2, d); chk("rstwr_keep", 32'(d), 32'h0605);

      // round-robin contention from reset: B, A, B, A
      a_req = 1'b1; a_wa = 6'd20; a_wd = 8'h11;
      b_req = 1'b1; b_wa = 6'd21; b_wd = 8'h22;
      for (int i = 0; i < 4; i++) begin
         tick;
         chk("rr_gnt", 32'({a_gnt, b_gnt}), (i % 2 == 0) ? 32'h1 : 32'h2);
      end
      a_req = 1'b0; b_req = 1'b0;
      tick; chk("rr_idle", 32'({a_gnt, b_gnt}), 32'h0);
      rd(5'd10, 2, d); chk("rr_data", 32'(d), 32'h2211);

      // fixed priority: both held 3 cycles, B starves
      rst = 1'b1;
      tick;
      rst = 1'b0;
      a_req = 1'b1; b_req = 1'b1;
      na = 0; nb = 0;
      repeat (3) begin
         tick;
         na += int'(fa_gnt);
         nb += int'(fb_gnt);
      end
      a_req = 1'b0; b_req = 1'b0;
      tick;
      na += int'(fa_gnt);
      nb += int'(fb_gnt);
      chk("fp_a_cnt", 32'(na), 32'd3);
      chk("fp_b_cnt", 32'(nb), 32'd0);

      // r_req held 6 cycles: 3 pulses, busy only drops on valid cycles
      r_addr = 5'd0; r_req = 1'b1;
      np = 0; nbad = 0;
      for (int i = 0; i < 6; i++) begin
         tick;
         if (r_valid) np++;
         else if (!r_busy) nbad++;
      end
      r_req = 1'b0;
      repeat (3) begin
         tick;
         if (r_valid) np++;
      end
      chk("b2b_pulses", 32'(np), 32'd3);
      chk("b2b_busy",   32'(nbad), 32'd0);
      chk("b2b_idle",   32'(r_busy), 32'd0);
      chk("b2b_data",   32'(r_data), 32'h0605);

      // reset the cycle after a read is accepted
      r_req = 1'b1; r_addr = 5'd0;
      tick; chk("rstrd_busy0", 32'(r_busy), 32'd1);
      r_req = 1'b0; rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("rstrd_busy1", 32'(r_busy), 32'd0);
      nv = 0;
      repeat (4) begin
         tick;
         nv += int'(r_valid);
      end
      chk("rstrd_valid", 32'(nv), 32'd0);
      chk("rstrd_busy2", 32'(r_busy), 32'd0);
      chk("rstrd_data",  32'(r_data), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
